rr_mux_4x1_4bit: RTL



---
 rtl/rr_mux_4x1_4bit.sv | 108 ++++++++++
 1 files changed

// File: rtl/rr_mux_4x1_4bit.sv
// rr_mux_4x1_4bit
//   Merges four WIDTH-bit valid/ready channels (a, b, c, d) into one
//   registered output stream. Channels are granted round-robin starting from
//   a rotating pointer. Each output beat is tagged with its source channel so
//   a downstream 1x4 demux can route it back.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   a,b,c,d    channel 0..3 data
//   valid[3:0] per-channel valid (bit0=a .. bit3=d)
//   ready[3:0] per-channel ready, combinational, at most one bit high
//   out        registered output data
//   out_sel    source channel of out (0=a .. 3=d)
//   out_valid  out/out_sel hold a beat
//   out_ready  consumer accepts the beat this cycle
module rr_mux_4x1_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       valid,
  output logic [3:0]       ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       ptr_reg;
  logic [WIDTH-1:0] out_reg;
  logic [1:0]       out_sel_reg;
  logic             out_valid_reg;

  logic [WIDTH-1:0] chan_data [4];
  logic [1:0]       cand_idx  [4];
  logic [3:0]       cand_hit;
  logic             win_found;
  logic [1:0]       win_idx;
  logic             can_accept;
  logic             grant_en;
  logic             xfer;

  assign chan_data[0] = a;
  assign chan_data[1] = b;
  assign chan_data[2] = c;
  assign chan_data[3] = d;

  // Candidate gi is the channel gi steps after the pointer (2-bit wrap).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = ptr_reg + 2'(gi);
      assign cand_hit[gi] = valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate back to the pointer so the nearest
  // requesting channel overwrites the others and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  assign can_accept = !out_valid_reg || out_ready;
  assign grant_en   = !rst && can_accept && win_found;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
      assign ready[gi] = grant_en && (win_idx == 2'(gi));
    end
  endgenerate

  // ready is only raised for a valid winner, so a grant is a transfer.
  assign xfer = grant_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= 2'd0;
      out_reg       <= '0;
      out_sel_reg   <= 2'd0;
      out_valid_reg <= 1'b0;
    end else if (xfer) begin
      // Covers both an empty register and simultaneous drain-and-fill.
      out_reg       <= chan_data[win_idx];
      out_sel_reg   <= win_idx;
      out_valid_reg <= 1'b1;
      ptr_reg       <= win_idx + 2'd1;
    end else if (out_valid_reg && out_ready) begin
      // Drain only: data and tag keep their last values.
      out_valid_reg <= 1'b0;
    end
  end

  assign out       = out_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule
